// File: rtl/ldpc_dec_pkg.sv
// ldpc_dec_pkg: shared defaults, state type and helper functions for the
// LDPC decoder core (ldpc_dec) and its hard-decision slicer.
//   LDPC_ZC / LDPC_VWIDTH / LDPC_DEC_OUT_LIFTING / LDPC_APP_ADDR_WIDTH : defaults
//   dec_state_e : decoder FSM states
//   num_groups(): lifted-column groups per frame for a code mode
//   sat_add()   : signed saturating add of two LLRs (soft combining)
package ldpc_dec_pkg;

    localparam int LDPC_ZC              = 64;
    localparam int LDPC_VWIDTH          = 8;
    localparam int LDPC_DEC_OUT_LIFTING = 8;
    localparam int LDPC_APP_ADDR_WIDTH  = 6;
    localparam int LDPC_MAX_GROUPS      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DECODE = 2'd2,
        ST_OUTPUT = 2'd3
    } dec_state_e;

    // Mode 2 is the short code (3 groups / 24 columns); all others use 4 groups.
    function automatic logic [2:0] num_groups(input logic [2:0] ils);
        return (ils == 3'd2) ? 3'd3 : 3'd4;
    endfunction

    function automatic logic [LDPC_VWIDTH-1:0] sat_add(input logic [LDPC_VWIDTH-1:0] a,
                                                       input logic [LDPC_VWIDTH-1:0] b);
        logic [LDPC_VWIDTH:0] s;
        s = {a[LDPC_VWIDTH-1], a} + {b[LDPC_VWIDTH-1], b};
        // The two top bits differ only on signed overflow.
        if (s[LDPC_VWIDTH] != s[LDPC_VWIDTH-1])
            return s[LDPC_VWIDTH] ? {1'b1, {(LDPC_VWIDTH-1){1'b0}}}
                                  : {1'b0, {(LDPC_VWIDTH-1){1'b1}}};
        return s[LDPC_VWIDTH-1:0];
    endfunction

endpackage

// File: rtl/ldpc_dec_hard_slicer.sv
// ldpc_hard_slicer: combinational hard decision for one group of column words.
// Each output bit is the sign (MSB) of one LLR, so a negative LLR gives 1.
//   cols_i : NCOL column words, word c at [c*ZC*VWIDTH +: ZC*VWIDTH],
//            LLR k of a word at [k*VWIDTH +: VWIDTH]
//   bits_o : NCOL*ZC sign bits, bit c*ZC+k is the sign of LLR k of word c
module ldpc_hard_slicer
    import ldpc_dec_pkg::*;
#(
    parameter int ZC     = LDPC_ZC,
    parameter int VWIDTH = LDPC_VWIDTH,
    parameter int NCOL   = LDPC_DEC_OUT_LIFTING
) (
    input  logic [NCOL*ZC*VWIDTH-1:0] cols_i,
    output logic [NCOL*ZC-1:0]        bits_o
);

    always_comb begin
        bits_o = '0;
        for (int c = 0; c < NCOL; c++) begin
            for (int k = 0; k < ZC; k++) begin
                bits_o[c*ZC + k] = cols_i[(c*ZC + k)*VWIDTH + VWIDTH - 1];
            end
        end
    end

endmodule

// File: rtl/ldpc_dec.sv
// ldpc_dec: LDPC decoder core. Loads channel LLRs a group (8 lifted columns)
// per beat into the APP store, waits a programmable decode latency, then emits
// hard decisions one group per beat.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   APPmsg_ini_subx_0..7        : column words 0..7 of the group being loaded
//   APPmsg_ini_sub_x            : group index of the load beat
//   buffer_valid/start/last     : load beat valid, frame start, final beat
//   iLs                         : code mode (2 -> 3 groups, else 4), latched at DECODE entry
//   P                           : decode latency in cycles (0 behaves as 1)
//   jLs, APP_addr_max, APP_addr_rd_max : reserved
//   buffer_ready                : registered, high while loading is possible
//   decode_valid, decode_valid_cnt, APPmsg_decode_out : output beat, group index, bits
// Build option: define LDPC_DEC_CHAN_ACC_EN to soft-combine repeated loads of a
// group with a saturating add instead of overwriting.
// Handshake: a load beat is taken on any clk edge where buffer_valid is high
// while buffer_ready is high; output beats carry no back-pressure and are
// valid only in the cycles where decode_valid is high.
module ldpc_dec
    import ldpc_dec_pkg::*;
#(
    parameter int ZC              = LDPC_ZC,
    parameter int VWIDTH          = LDPC_VWIDTH,
    parameter int DEC_OUT_LIFTING = LDPC_DEC_OUT_LIFTING,
    parameter int APP_ADDR_WIDTH  = LDPC_APP_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_0,
    input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_1,
    input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_2,
    input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_3,
    input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_4,
    input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_5,
    input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_6,
    input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_7,
    input  logic [1:0]                    APPmsg_ini_sub_x,
    input  logic                          buffer_valid,
    input  logic                          buffer_start,
    input  logic                          buffer_last,
    input  logic [2:0]                    iLs,
    input  logic [2:0]                    jLs,
    input  logic [5:0]                    P,
    input  logic [APP_ADDR_WIDTH-1:0]     APP_addr_max,
    input  logic [APP_ADDR_WIDTH-2:0]     APP_addr_rd_max,
    output logic                          buffer_ready,
    output logic                          decode_valid,
    output logic [2:0]                    decode_valid_cnt,
    output logic [ZC*DEC_OUT_LIFTING-1:0] APPmsg_decode_out
);

    // The port list carries exactly 8 column words, so DEC_OUT_LIFTING must be 8.
    localparam int NCOL  = DEC_OUT_LIFTING;
    localparam int CBITS = $clog2(NCOL);
    localparam int WORD  = ZC*VWIDTH;
    localparam int NSLOT = LDPC_MAX_GROUPS*NCOL;

    logic [WORD-1:0]      in_w [NCOL];
    logic [WORD-1:0]      wr_word [NCOL];
    logic [WORD-1:0]      store_q [NSLOT];

    dec_state_e           state_q, state_d;
    logic [5:0]           lat_q, lat_d;
    logic [1:0]           out_cnt_q, out_cnt_d;
    logic [2:0]           ng_q, ng_d;
    logic [3:0]           mask_q, mask_d;
    logic                 buffer_ready_q;
    logic                 decode_valid_q, decode_valid_d;
    logic [ZC*NCOL-1:0]   dec_out_q, dec_out_d;

    logic                 load_phase;
    logic                 wr_en;
    logic [1:0]           sel_grp;
    logic [NCOL*WORD-1:0] slice_in;
    logic [ZC*NCOL-1:0]   slice_bits;
    logic [ZC*NCOL-1:0]   grp_bits;
    logic                 unused_reserved;

    assign unused_reserved = ^{jLs, APP_addr_max, APP_addr_rd_max};

    assign in_w[0] = APPmsg_ini_subx_0;
    assign in_w[1] = APPmsg_ini_subx_1;
    assign in_w[2] = APPmsg_ini_subx_2;
    assign in_w[3] = APPmsg_ini_subx_3;
    assign in_w[4] = APPmsg_ini_subx_4;
    assign in_w[5] = APPmsg_ini_subx_5;
    assign in_w[6] = APPmsg_ini_subx_6;
    assign in_w[7] = APPmsg_ini_subx_7;

    // ---------------- load path ----------------
    assign load_phase = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    // Groups beyond the live code size are dropped, not stored.
    assign wr_en = load_phase && buffer_valid
                && ({1'b0, APPmsg_ini_sub_x} < num_groups(iLs));

    // A start pulse clears the mask before the same-cycle beat sets its bit.
    always_comb begin
        mask_d = mask_q;
        if (load_phase) begin
            if (buffer_start) mask_d = '0;
            if (wr_en)        mask_d[APPmsg_ini_sub_x] = 1'b1;
        end
    end

`ifdef LDPC_DEC_CHAN_ACC_EN
    logic acc_en;
    // Combine only into a group already loaded in this frame.
    assign acc_en = mask_q[APPmsg_ini_sub_x] && !buffer_start;
`endif

    always_comb begin
        for (int c = 0; c < NCOL; c++) begin
            wr_word[c] = in_w[c];
`ifdef LDPC_DEC_CHAN_ACC_EN
            if (acc_en) begin
                for (int k = 0; k < ZC; k++) begin
                    wr_word[c][k*VWIDTH +: VWIDTH] =
                        sat_add(store_q[{APPmsg_ini_sub_x, CBITS'(c)}][k*VWIDTH +: VWIDTH],
                                in_w[c][k*VWIDTH +: VWIDTH]);
                end
            end
`endif
        end
    end

    // ---------------- output path ----------------
    // Group feeding the output register at the next edge.
    always_comb begin
        sel_grp = (state_q == ST_OUTPUT) ? out_cnt_q + 2'd1 : 2'd0;
    end

    always_comb begin
        slice_in = '0;
        for (int c = 0; c < NCOL; c++) begin
            slice_in[c*WORD +: WORD] = store_q[{sel_grp, CBITS'(c)}];
        end
    end

    ldpc_hard_slicer #(
        .ZC     (ZC),
        .VWIDTH (VWIDTH),
        .NCOL   (NCOL)
    ) u_slicer (
        .cols_i (slice_in),
        .bits_o (slice_bits)
    );

    // Unloaded groups read as all zeros regardless of stale store contents.
    assign grp_bits = slice_bits & {(ZC*NCOL){mask_q[sel_grp]}};

    // ---------------- FSM ----------------
    always_comb begin
        state_d        = state_q;
        lat_d          = lat_q;
        out_cnt_d      = out_cnt_q;
        ng_d           = ng_q;
        decode_valid_d = 1'b0;
        dec_out_d      = '0;
        unique case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (buffer_last) begin
                    state_d = ST_DECODE;
                    lat_d   = (P == 6'd0) ? 6'd1 : P;
                    ng_d    = num_groups(iLs);
                end else if (buffer_start || buffer_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_DECODE: begin
                lat_d = lat_q - 6'd1;
                if (lat_q <= 6'd1) begin
                    state_d        = ST_OUTPUT;
                    out_cnt_d      = 2'd0;
                    decode_valid_d = 1'b1;
                    dec_out_d      = grp_bits;
                end
            end
            ST_OUTPUT: begin
                if ({1'b0, out_cnt_q} == ng_q - 3'd1) begin
                    state_d   = ST_IDLE;
                    out_cnt_d = 2'd0;
                end else begin
                    out_cnt_d      = out_cnt_q + 2'd1;
                    decode_valid_d = 1'b1;
                    dec_out_d      = grp_bits;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            lat_q          <= '0;
            out_cnt_q      <= '0;
            ng_q           <= '0;
            mask_q         <= '0;
            buffer_ready_q <= 1'b0;
            decode_valid_q <= 1'b0;
            dec_out_q      <= '0;
            for (int s = 0; s < NSLOT; s++) store_q[s] <= '0;
        end else begin
            state_q        <= state_d;
            lat_q          <= lat_d;
            out_cnt_q      <= out_cnt_d;
            ng_q           <= ng_d;
            mask_q         <= mask_d;
            buffer_ready_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
            decode_valid_q <= decode_valid_d;
            dec_out_q      <= dec_out_d;
            if (wr_en) begin
                for (int c = 0; c < NCOL; c++) begin
                    store_q[{APPmsg_ini_sub_x, CBITS'(c)}] <= wr_word[c];
                end
            end
        end
    end

    assign buffer_ready      = buffer_ready_q;
    assign decode_valid      = decode_valid_q;
    assign decode_valid_cnt  = {1'b0, out_cnt_q};
    assign APPmsg_decode_out = dec_out_q;

endmodule

// File: tb/tb_ldpc_dec.sv
`timescale 1ns/1ps
module tb_ldpc_dec;

    localparam int ZC   = 64;
    localparam int VW   = 8;
    localparam int NCOL = 8;
    localparam int WORD = ZC*VW;
    localparam int OUTW = ZC*NCOL;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [WORD-1:0] beat_w [NCOL];
    logic [1:0]      grp = '0;
    logic            b_valid = 1'b0, b_start = 1'b0, b_last = 1'b0;
    logic [2:0]      ils = 3'd1, jls = 3'd0;
    logic [5:0]      p_lat = 6'd1;
    logic [5:0]      addr_max = 6'd0;
    logic [4:0]      addr_rd_max = 5'd0;
    logic            buffer_ready, decode_valid;
    logic [2:0]      decode_valid_cnt;
    logic [OUTW-1:0] dec_out;

    ldpc_dec u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .APPmsg_ini_subx_0 (beat_w[0]),
        .APPmsg_ini_subx_1 (beat_w[1]),
        .APPmsg_ini_subx_2 (beat_w[2]),
        .APPmsg_ini_subx_3 (beat_w[3]),
        .APPmsg_ini_subx_4 (beat_w[4]),
        .APPmsg_ini_subx_5 (beat_w[5]),
        .APPmsg_ini_subx_6 (beat_w[6]),
        .APPmsg_ini_subx_7 (beat_w[7]),
        .APPmsg_ini_sub_x  (grp),
        .buffer_valid      (b_valid),
        .buffer_start      (b_start),
        .buffer_last       (b_last),
        .iLs               (ils),
        .jLs               (jls),
        .P                 (p_lat),
        .APP_addr_max      (addr_max),
        .APP_addr_rd_max   (addr_rd_max),
        .buffer_ready      (buffer_ready),
        .decode_valid      (decode_valid),
        .decode_valid_cnt  (decode_valid_cnt),
        .APPmsg_decode_out (dec_out)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [OUTW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [OUTW-1:0] got, input logic [OUTW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Store as signed integers per slot and LLR, plus a loaded flag per group.
    int      m_llr [32][ZC];
    bit [3:0] m_mask;

    function automatic int ng_of(input logic [2:0] v);
        return (v == 3'd2) ? 3 : 4;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 32; s++)
            for (int k = 0; k < ZC; k++) m_llr[s][k] = 0;
        m_mask = '0;
    endtask

    task automatic model_load(input int g, input bit start, input bit valid);
        int v;
        int s;
        if (start) m_mask = '0;
        if (valid && g < ng_of(ils)) begin
            for (int c = 0; c < NCOL; c++) begin
                for (int k = 0; k < ZC; k++) begin
                    v = int'($signed(beat_w[c][k*VW +: VW]));
`ifdef LDPC_DEC_CHAN_ACC_EN
                    if (m_mask[g]) begin
                        s = m_llr[g*8 + c][k] + v;
                        v = (s > 127) ? 127 : ((s < -128) ? -128 : s);
                    end
`else
                    s = 0;
`endif
                    m_llr[g*8 + c][k] = v;
                end
            end
            m_mask[g] = 1'b1;
        end
    endtask

    function automatic logic [OUTW-1:0] model_group(input int j);
        logic [OUTW-1:0] e;
        e = '0;
        if (m_mask[j]) begin
            for (int c = 0; c < NCOL; c++)
                for (int k = 0; k < ZC; k++)
                    e[c*ZC + k] = (m_llr[j*8 + c][k] < 0);
        end
        return e;
    endfunction

    // ---------------- drivers ----------------
    task automatic fill_const(input logic [7:0] b);
        for (int c = 0; c < NCOL; c++) beat_w[c] = {ZC{b}};
    endtask

    task automatic fill_rand();
        for (int c = 0; c < NCOL; c++)
            for (int k = 0; k < ZC; k++) beat_w[c][k*VW +: VW] = 8'($urandom_range(0, 255));
    endtask

    // Called 1ns after a rising edge; presents one beat for one edge.
    task automatic drive_beat(input int g, input bit start, input bit valid, input bit last);
        grp     = 2'(g);
        b_start = start;
        b_valid = valid;
        b_last  = last;
        @(posedge clk);
        model_load(g, start, valid);
        #1;
        b_start = 1'b0;
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called right after the edge that took buffer_last; checks latency and all beats.
    task automatic run_decode(input string name);
        int ng;
        int p_eff;
        int n;
        bit seen;
        ng    = ng_of(ils);
        p_eff = (p_lat == 6'd0) ? 1 : int'(p_lat);
        exp_q.delete();
        for (int j = 0; j < ng; j++) exp_q.push_back(model_group(j));
        check({name, ":ready_drop"}, buffer_ready, 0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < p_eff + 8) begin
            @(posedge clk);
            #1;
            n++;
            if (decode_valid) seen = 1'b1;
            else check({name, ":ready_decode"}, buffer_ready, 0);
        end
        check({name, ":latency"}, n, p_eff);
        if (!seen) return;
        for (int j = 0; j < ng; j++) begin
            if (j > 0) idle_cycle();
            check({name, ":valid"}, decode_valid, 1);
            check({name, ":cnt"}, decode_valid_cnt, j);
            check({name, ":data"}, dec_out, exp_q.pop_front());
            check({name, ":ready_out"}, buffer_ready, 0);
        end
        idle_cycle();
        check({name, ":valid_end"}, decode_valid, 0);
        check({name, ":data_end"}, dec_out, 0);
        check({name, ":ready_end"}, buffer_ready, 1);
    endtask

    task automatic load_random_frame(input int nbeats, input bit last_with_valid);
        for (int b = 0; b < nbeats; b++) begin
            fill_rand();
            if ($urandom_range(0, 3) == 0) idle_cycle();
            drive_beat($urandom_range(0, 3), (b == 0) ? 1'b1 : 1'b0, 1'b1,
                       (b == nbeats - 1) && last_with_valid);
        end
        if (!last_with_valid) drive_beat(0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        fill_const(8'h00);
        model_reset();

        // Reset state and release
        repeat (3) @(posedge clk);
        #1;
        check("rst:ready", buffer_ready, 0);
        check("rst:valid", decode_valid, 0);
        check("rst:data", dec_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        check("rel:ready", buffer_ready, 1);
        check("rel:valid", decode_valid, 0);

        // Four groups, group 2 positive, others negative
        ils = 3'd1; p_lat = 6'd32;
        fill_const(8'hF0); drive_beat(0, 1, 1, 0);
        drive_beat(1, 0, 1, 0);
        fill_const(8'h10); drive_beat(2, 0, 1, 0);
        fill_const(8'hF0); drive_beat(3, 0, 1, 1);
        run_decode("ils1_p32");

        // Short code; a group-3 beat must be dropped
        ils = 3'd2; p_lat = 6'd5;
        fill_rand(); drive_beat(0, 1, 1, 0);
        fill_rand(); drive_beat(1, 0, 1, 0);
        fill_rand(); drive_beat(2, 0, 1, 0);
        fill_const(8'h80); drive_beat(3, 0, 1, 1);
        run_decode("ils2_drop_g3");

        // Partial load; last arrives without a beat
        ils = 3'd1; p_lat = 6'd3;
        fill_rand(); drive_beat(0, 1, 1, 0);
        drive_beat(0, 0, 0, 1);
        run_decode("partial");

        // Repeated loads of group 0, latency 0 behaves as 1
        ils = 3'd0; p_lat = 6'd0;
        fill_const(8'h60); drive_beat(0, 1, 1, 0);
        drive_beat(0, 0, 1, 1);
        run_decode("rep_60_60");
        fill_const(8'h60); drive_beat(0, 1, 1, 0);
        fill_const(8'hA0); drive_beat(0, 0, 1, 1);
        run_decode("rep_60_a0");

        // Reset asserted during DECODE
        ils = 3'd1; p_lat = 6'd20;
        load_random_frame(4, 1'b1);
        repeat (5) idle_cycle();
        rst_n = 1'b0;
        #1;
        check("midrst:valid", decode_valid, 0);
        check("midrst:ready", buffer_ready, 0);
        check("midrst:cnt", decode_valid_cnt, 0);
        check("midrst:data", dec_out, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        check("midrst:ready_rel", buffer_ready, 1);
        ils = 3'd1; p_lat = 6'd4;
        load_random_frame(5, 1'b1);
        run_decode("after_rst");

        // Randomized frames
        for (int it = 0; it < 25; it++) begin
            ils   = 3'($urandom_range(0, 7));
            p_lat = 6'($urandom_range(0, 12));
            load_random_frame($urandom_range(1, 6), $urandom_range(0, 1) == 1);
            run_decode($sformatf("rand%0d", it));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ldpc_dec.md
Name: ldpc_dec

Overview:
- LDPC decoder core beneath the LDPC decode top-level wrapper.
- Loads channel LLRs in groups of 8 lifted columns into an internal APP store.
- After a fixed decode latency, emits hard-decision bits one group per beat.
- Supports two code configurations selected by iLs: 4 groups (32 columns) or 3 groups (24 columns).

Parameters:
- ZC, 64, lifting size (LLRs per column word).
- VWIDTH, 8, LLR width in bits, two's complement.
- DEC_OUT_LIFTING, 8, columns per output beat (output width ZC*DEC_OUT_LIFTING).
- APP_ADDR_WIDTH, 6, width of the APP address-limit inputs.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- APPmsg_ini_subx_0..APPmsg_ini_subx_7  in  ZC*VWIDTH each  column words c=0..7 of the current group
- APPmsg_ini_sub_x  in  2  group index g of the current load beat
- buffer_valid  in  1  load beat valid
- buffer_start  in  1  frame start pulse
- buffer_last  in  1  final load beat of the frame
- iLs  in  3  code mode: 2 selects 3 groups; any other value selects 4 groups
- jLs  in  3  reserved, no effect
- P  in  6  decode latency in cycles; 0 is treated as 1
- APP_addr_max  in  APP_ADDR_WIDTH  reserved, no effect
- APP_addr_rd_max  in  APP_ADDR_WIDTH-1  reserved, no effect
- buffer_ready  out  1  core accepts load beats
- decode_valid  out  1  output beat valid
- decode_valid_cnt  out  3  group index of the current output beat
- APPmsg_decode_out  out  ZC*DEC_OUT_LIFTING  hard decisions for the current group

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; store and loaded-mask cleared.
- States: IDLE, LOAD, DECODE, OUTPUT.
- buffer_ready is registered; it is 1 in IDLE and LOAD and 0 in DECODE and OUTPUT. It reaches 1 on the first clk edge after reset release.
- IDLE to LOAD on buffer_start or buffer_valid.
- On buffer_start, the loaded-mask clears. If buffer_valid is also set that cycle, its beat is stored after the clear.
- Load beat (buffer_valid in IDLE or LOAD):
  - Column word c of group g goes to store slot g*8+c, and mask bit g is set.
  - Overwrite semantics; repeated beats for the same group are legal.
  - Writes with g >= NG are ignored (NG = 3 if iLs==2, else 4).
- buffer_last with buffer_valid: that beat is stored, then the next state is DECODE and the latency counter loads P.
- buffer_last without buffer_valid: ends the load in the same way.
- DECODE: the counter decrements each cycle; on reaching 0 the state moves to OUTPUT. Output starts P cycles after DECODE entry.
- OUTPUT: decode_valid is high for exactly NG consecutive cycles.
  - decode_valid_cnt runs 0..NG-1.
  - Out bits [c*ZC+k] = MSB of LLR k of slot (cnt*8+c), so a negative LLR gives 1.
  - LLR k occupies bits [k*VWIDTH +: VWIDTH] of its column word.
  - Groups with mask bit 0 output all zeros.
  - After the last beat: IDLE; decode_valid and APPmsg_decode_out return to 0 the next cycle.
- buffer_valid, buffer_start and buffer_last are ignored in DECODE and OUTPUT.
- iLs is sampled at DECODE entry to fix NG for that frame.
- Reset asserted mid-frame aborts immediately to reset values.

Optional Feature:
- Macro LDPC_DEC_CHAN_ACC_EN.
- Defined: a repeated load of a group whose mask bit is already set performs a per-LLR saturating signed add (clamp to [-2^(VWIDTH-1), 2^(VWIDTH-1)-1]) into the store (soft combining).
- Defined: the first load of a group after buffer_start overwrites.
- Undefined: plain overwrite.

Decomposition:
- Package ldpc_dec_pkg: ZC, VWIDTH, DEC_OUT_LIFTING, APP_ADDR_WIDTH defaults; state enum; group-count function of iLs; saturating-add function.
- One sub-module, ldpc_hard_slicer: 8 column words in, ZC*8 sign bits out. It is combinational and feeds the output register.

Test Plan:
- Reset release: buffer_ready 0 during reset and 1 one cycle after release; decode_valid 0.
- iLs=1, P=32, four groups loaded with all LLRs 8'hF0 except group 2 all 8'h10, then buffer_last: 32 cycles later, 4 beats with cnt 0,1,2,3; out all-ones except cnt=2 all-zeros.
- iLs=2, groups 0..2 loaded, plus one g=3 beat: exactly 3 beats; g=3 data never appears.
- Partial load (only group 0), iLs=1: beats cnt 1..3 all zeros; buffer_ready 0 from DECODE entry until the last output beat.
- LDPC_DEC_CHAN_ACC_EN: load group 0 as 8'h60 twice gives MSB 0 (saturates to 8'h7F); 8'h60 then 8'hA0 gives 0x00, MSB 0; without the macro, 8'h60 then 8'hA0 outputs 1s.
- Assert rst_n low during DECODE: outputs return to 0 immediately; a fresh frame afterwards decodes correctly.
